// File: rtl/fetch_unit_pkg.sv
// Shared types for the fetch stage: next-PC select, HALT tracking states and the IF/ID latch layout.
package fetch_unit_pkg;

  typedef enum logic [1:0] {
    PC4    = 2'd0,
    BRANCH = 2'd1,
    JUMP   = 2'd2,
    JR     = 2'd3
  } PCSrc_t;

  typedef enum logic [1:0] {
    FETCH     = 2'd0,
    HALT_PEND = 2'd1,
    HALTED    = 2'd2
  } fetch_state_t;

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] npc;
    logic        valid;
  } ifid_t;

  localparam logic [5:0] HALT_OPCODE = 6'h3F;

  localparam ifid_t IFID_BUBBLE = '{instr: 32'h0, npc: 32'h0, valid: 1'b0};

  function automatic logic is_halt(input logic [31:0] instr, input logic [5:0] op);
    return instr[31:26] == op;
  endfunction

endpackage

// File: rtl/fetch_unit_if.sv
// Instruction-memory port between the fetch stage (master) and the memory/cache (slave).
interface fetch_unit_if;

  logic        ihit;
  logic [31:0] imemload;
  logic [31:0] imemaddr;
  logic        imemREN;

  modport master (
    input  ihit,
    input  imemload,
    output imemaddr,
    output imemREN
  );

  modport slave (
    output ihit,
    output imemload,
    input  imemaddr,
    input  imemREN
  );

endinterface

// File: rtl/fetch_unit_npc_sel.sv
// Combinational next-PC mux; PC+4 is also exported because the IF/ID latch records it.
module npc_sel
  import fetch_unit_pkg::*;
(
  input  logic [31:0] pc,
  input  PCSrc_t      pc_src,
  input  logic [31:0] br_target,
  input  logic [31:0] j_target,
  input  logic [31:0] jr_target,
  output logic [31:0] pc_plus4,
  output logic [31:0] next_pc
);

  assign pc_plus4 = pc + 32'd4;

  always_comb begin
    next_pc = pc_plus4;
    case (pc_src)
      PC4:     next_pc = pc_plus4;
      BRANCH:  next_pc = br_target;
      JUMP:    next_pc = j_target;
      JR:      next_pc = jr_target;
      default: next_pc = pc_plus4;
    endcase
  end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage with the IF/ID pipeline latch, PC redirects and HALT tracking.
module fetch_unit
  import fetch_unit_pkg::*;
#(
  parameter logic [31:0] PC_INIT = 32'h0000_0000,
  parameter logic [5:0]  HALT_OP = HALT_OPCODE
) (
  input  logic                CLK,
  input  logic                nRST,
  fetch_unit_if.master        imem,
  input  logic                pc_en,
  input  logic                id_en,
  input  logic                flushed,
  input  PCSrc_t              pc_src,
  input  logic [31:0]         br_target,
  input  logic [31:0]         j_target,
  input  logic [31:0]         jr_target,
  output logic [31:0]         ifid_instr,
  output logic [31:0]         ifid_npc,
  output logic                ifid_valid,
  output logic                halt_out,
  output logic [31:0]         fetch_cnt
);

  fetch_state_t state_q, state_d;
  logic [31:0]  pc_q, pc_d;
  ifid_t        ifid_q, ifid_d;
  logic [31:0]  cnt_q, cnt_d;
  logic [31:0]  pc_plus4;
  logic [31:0]  next_pc;
  logic         fetching;
  logic         load_word;

  npc_sel u_npc_sel (
    .pc        (pc_q),
    .pc_src    (pc_src),
    .br_target (br_target),
    .j_target  (j_target),
    .jr_target (jr_target),
    .pc_plus4  (pc_plus4),
    .next_pc   (next_pc)
  );

  assign fetching  = (state_q == FETCH);
  assign load_word = !flushed && id_en && imem.ihit && fetching;

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state_q <= FETCH;
    end else begin
      state_q <= state_d;
    end
  end

  // A HALT only stops the core once it reaches ID unsquashed; a flush while pending resumes fetching.
  always_comb begin
    state_d = state_q;
    case (state_q)
      FETCH: begin
        if (load_word && is_halt(imem.imemload, HALT_OP)) state_d = HALT_PEND;
      end
      HALT_PEND: begin
        if (flushed)    state_d = FETCH;
        else if (id_en) state_d = HALTED;
      end
      HALTED:  state_d = HALTED;
      default: state_d = FETCH;
    endcase
  end

  always_comb begin
    pc_d   = pc_q;
    ifid_d = ifid_q;
    cnt_d  = cnt_q;
    if (state_q != HALTED) begin
      // Redirects win over sequential fetch even without ihit; the pending read is simply dropped.
      if (pc_en) begin
        if (pc_src != PC4)            pc_d = next_pc;
        else if (imem.ihit && fetching) pc_d = pc_plus4;
      end
      if (flushed) begin
        ifid_d = IFID_BUBBLE;
      end else if (load_word) begin
        ifid_d = '{instr: imem.imemload, npc: pc_plus4, valid: 1'b1};
        cnt_d  = cnt_q + 32'd1;
      end else if (id_en) begin
        ifid_d = IFID_BUBBLE;
      end
    end
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      pc_q   <= PC_INIT;
      ifid_q <= IFID_BUBBLE;
      cnt_q  <= 32'h0;
    end else begin
      pc_q   <= pc_d;
      ifid_q <= ifid_d;
      cnt_q  <= cnt_d;
    end
  end

  assign imem.imemaddr = pc_q;
  assign imem.imemREN  = fetching;
  assign ifid_instr    = ifid_q.instr;
  assign ifid_npc      = ifid_q.npc;
  assign ifid_valid    = ifid_q.valid;
  assign halt_out      = (state_q == HALTED);
  assign fetch_cnt     = cnt_q;

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: directed scenarios plus randomized traffic against a behavioural model.
module tb_fetch_unit;
  import fetch_unit_pkg::*;

  logic        CLK = 1'b0;
  logic        nRST;
  logic        pc_en, id_en, flushed;
  PCSrc_t      pc_src;
  logic [31:0] br_target, j_target, jr_target;
  logic [31:0] ifid_instr, ifid_npc, fetch_cnt;
  logic        ifid_valid, halt_out;

  int total = 0;
  int bad   = 0;

  // Model: mode 0 = fetching, 1 = halt pending, 2 = halted.
  logic [31:0] m_pc, m_instr, m_npc, m_cnt;
  logic        m_valid;
  int          m_mode;

  fetch_unit_if imem();

  fetch_unit #(.PC_INIT(32'h0), .HALT_OP(6'h3F)) dut (
    .CLK        (CLK),
    .nRST       (nRST),
    .imem       (imem),
    .pc_en      (pc_en),
    .id_en      (id_en),
    .flushed    (flushed),
    .pc_src     (pc_src),
    .br_target  (br_target),
    .j_target   (j_target),
    .jr_target  (jr_target),
    .ifid_instr (ifid_instr),
    .ifid_npc   (ifid_npc),
    .ifid_valid (ifid_valid),
    .halt_out   (halt_out),
    .fetch_cnt  (fetch_cnt)
  );

  always #5 CLK = ~CLK;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %h, expected %h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic checkAll();
    checkOutput("imemaddr", imem.imemaddr, m_pc);
    checkOutput("imemREN", {31'h0, imem.imemREN}, {31'h0, m_mode == 0});
    checkOutput("ifid_instr", ifid_instr, m_instr);
    checkOutput("ifid_npc", ifid_npc, m_npc);
    checkOutput("ifid_valid", {31'h0, ifid_valid}, {31'h0, m_valid});
    checkOutput("halt_out", {31'h0, halt_out}, {31'h0, m_mode == 2});
    checkOutput("fetch_cnt", fetch_cnt, m_cnt);
  endtask

  task automatic modelReset();
    m_pc = 32'h0; m_instr = 32'h0; m_npc = 32'h0; m_cnt = 32'h0;
    m_valid = 1'b0; m_mode = 0;
  endtask

  task automatic applyStimulus(input logic hit, input logic [31:0] word, input logic pen,
                               input logic ien, input logic fl, input PCSrc_t src,
                               input logic [31:0] br, input logic [31:0] jt, input logic [31:0] jr);
    logic [31:0] n_pc, n_instr, n_npc, n_cnt;
    logic        n_valid, took;
    int          n_mode;
    imem.ihit = hit; imem.imemload = word;
    pc_en = pen; id_en = ien; flushed = fl; pc_src = src;
    br_target = br; j_target = jt; jr_target = jr;
    n_pc = m_pc; n_instr = m_instr; n_npc = m_npc; n_cnt = m_cnt;
    n_valid = m_valid; n_mode = m_mode;
    if (m_mode != 2) begin
      if (pen) begin
        if (src == BRANCH)      n_pc = br;
        else if (src == JUMP)   n_pc = jt;
        else if (src == JR)     n_pc = jr;
        else if (hit && m_mode == 0) n_pc = m_pc + 32'd4;
      end
      took = !fl && ien && hit && (m_mode == 0);
      if (took) begin
        n_instr = word; n_npc = m_pc + 32'd4; n_valid = 1'b1; n_cnt = m_cnt + 32'd1;
      end else if (fl || ien) begin
        n_instr = 32'h0; n_npc = 32'h0; n_valid = 1'b0;
      end
      if (m_mode == 0 && took && word[31:26] == 6'h3F) n_mode = 1;
      else if (m_mode == 1 && fl)                      n_mode = 0;
      else if (m_mode == 1 && ien)                     n_mode = 2;
    end
    @(posedge CLK);
    #1;
    m_pc = n_pc; m_instr = n_instr; m_npc = n_npc; m_cnt = n_cnt;
    m_valid = n_valid; m_mode = n_mode;
    checkAll();
  endtask

  task automatic doReset();
    nRST = 1'b0;
    imem.ihit = 1'b0; imem.imemload = 32'h0;
    pc_en = 1'b0; id_en = 1'b0; flushed = 1'b0; pc_src = PC4;
    br_target = 32'h0; j_target = 32'h0; jr_target = 32'h0;
    repeat (2) @(posedge CLK);
    #1;
    modelReset();
    checkAll();
    @(negedge CLK);
    nRST = 1'b1;
  endtask

  initial begin
    logic [31:0] word, tgt;
    PCSrc_t      src;

    doReset();
    checkOutput("rst_pc", imem.imemaddr, 32'h0);
    checkOutput("rst_cnt", fetch_cnt, 32'h0);

    for (int i = 0; i < 3; i++) begin
      applyStimulus(1, 32'h2000_0001 + i, 1, 1, 0, PC4, 0, 0, 0);
      checkOutput("seq_pc", imem.imemaddr, 32'(4 * (i + 1)));
      checkOutput("seq_npc", ifid_npc, 32'(4 * (i + 1)));
    end
    checkOutput("seq_cnt", fetch_cnt, 32'd3);

    for (int i = 0; i < 2; i++) begin
      applyStimulus(0, 32'h2000_0007, 1, 1, 0, PC4, 0, 0, 0);
      checkOutput("miss_pc", imem.imemaddr, 32'hC);
      checkOutput("miss_valid", {31'h0, ifid_valid}, 32'h0);
    end
    checkOutput("miss_cnt", fetch_cnt, 32'd3);

    applyStimulus(0, 32'h0, 1, 1, 1, BRANCH, 32'h40, 0, 0);
    checkOutput("br_pc", imem.imemaddr, 32'h40);
    checkOutput("br_instr", ifid_instr, 32'h0);

    for (int i = 0; i < 3; i++) applyStimulus(1, 32'h1234_5678, 0, 0, 0, PC4, 0, 0, 0);
    checkOutput("stall_pc", imem.imemaddr, 32'h40);
    checkOutput("stall_cnt", fetch_cnt, 32'd3);

    applyStimulus(0, 32'h0, 1, 1, 1, JUMP, 0, 32'h10, 0);
    applyStimulus(1, 32'hFC00_0000, 1, 1, 0, PC4, 0, 0, 0);
    checkOutput("hpend_ren", {31'h0, imem.imemREN}, 32'h0);
    checkOutput("hpend_instr", ifid_instr, 32'hFC00_0000);
    applyStimulus(1, 32'h2000_0009, 1, 1, 1, JUMP, 0, 32'h80, 0);
    checkOutput("squash_pc", imem.imemaddr, 32'h80);
    checkOutput("squash_ren", {31'h0, imem.imemREN}, 32'h1);
    checkOutput("squash_halt", {31'h0, halt_out}, 32'h0);

    applyStimulus(1, 32'hFC00_0123, 1, 1, 0, PC4, 0, 0, 0);
    applyStimulus(0, 32'h0, 1, 1, 0, PC4, 0, 0, 0);
    checkOutput("halted_out", {31'h0, halt_out}, 32'h1);
    checkOutput("halted_ren", {31'h0, imem.imemREN}, 32'h0);
    applyStimulus(1, 32'h2000_0000, 1, 1, 0, JUMP, 0, 32'h200, 0);
    checkOutput("halted_pc", imem.imemaddr, 32'h84);
    checkOutput("halted_cnt", fetch_cnt, 32'd5);

    #3 nRST = 1'b0;
    #1;
    modelReset();
    checkOutput("async_pc", imem.imemaddr, 32'h0);
    checkOutput("async_halt", {31'h0, halt_out}, 32'h0);
    checkOutput("async_ren", {31'h0, imem.imemREN}, 32'h1);
    checkAll();
    @(negedge CLK);
    nRST = 1'b1;

    applyStimulus(0, 32'h0, 1, 1, 1, JR, 0, 0, 32'hFFFF_FFFC);
    applyStimulus(1, 32'h2000_0002, 1, 1, 0, PC4, 0, 0, 0);
    checkOutput("wrap_pc", imem.imemaddr, 32'h0);
    checkOutput("wrap_npc", ifid_npc, 32'h0);

    for (int r = 0; r < 8; r++) begin
      doReset();
      for (int c = 0; c < 80; c++) begin
        word = ($urandom_range(0, 7) == 0) ? {6'h3F, 26'($urandom)} : $urandom;
        src  = ($urandom_range(0, 4) == 0) ? PCSrc_t'($urandom_range(1, 3)) : PC4;
        tgt  = ($urandom_range(0, 9) == 0) ? 32'hFFFF_FFFC : ($urandom & 32'hFFFF_FFFC);
        applyStimulus($urandom_range(0, 3) != 0, word, $urandom_range(0, 7) != 0,
                      $urandom_range(0, 7) != 0, $urandom_range(0, 5) == 0, src,
                      tgt, tgt ^ 32'h0000_1000, tgt ^ 32'h0010_0000);
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
